// File: rtl/control_unit_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_multiciclo
// Description : Multicycle control FSM for the ARM-subset core, with NZCV
//               flags, retired-instruction counter and memory wait timeout.
//               Define COND_EXEC_EN for full ARM condition evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_multiciclo #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       Cond,
    input  logic [1:0]       Op,
    input  logic             I,
    input  logic [3:0]       OpCode,
    input  logic             S,
    input  logic             L1,
    input  logic             L2,
    input  logic [3:0]       alu_flags,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             LinkWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUControl,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             fault
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0100;
    localparam logic [3:0] c_OP_CMP = 4'b1010;
    localparam logic [3:0] c_OP_ORR = 4'b1100;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_ALUWB    = 4'd4,
        S_MEMADR   = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWB    = 4'd7,
        S_MEMWRITE = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        flags_q, flags_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              w_cond_pass;
    logic              w_stall;
    logic              w_is_cmp;
    logic [WAIT_W-1:0] w_wait_inc;

    assign flags      = flags_q;
    assign retired    = retired_q;
    assign w_is_cmp   = (OpCode == c_OP_CMP);
    assign w_wait_inc = wait_q + 1'b1;

`ifdef COND_EXEC_EN
    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = flags_q;

    always_comb begin
        case (Cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = !w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = !w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = !w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = !w_v;
            4'b1000: w_cond_pass = w_c && !w_z;
            4'b1001: w_cond_pass = !w_c || w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = !w_z && (w_n == w_v);
            4'b1101: w_cond_pass = w_z || (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end
`else
    logic w_unused_cond;
    assign w_unused_cond = ^Cond;
    assign w_cond_pass   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            flags_q   <= '0;
            retired_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        retired_d  = retired_q;
        wait_d     = '0;
        w_stall    = 1'b0;
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        LinkWrite  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        illegal    = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_DECODE: begin
                if (!w_cond_pass) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        2'b00:   state_d = S_EXEC;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                ALUSrcB = I ? 2'b01 : 2'b00;
                state_d = S_ALUWB;
                case (OpCode)
                    c_OP_ADD: ALUControl = 2'b00;
                    c_OP_SUB: ALUControl = 2'b01;
                    c_OP_AND: ALUControl = 2'b10;
                    c_OP_ORR: ALUControl = 2'b11;
                    c_OP_CMP: ALUControl = 2'b01;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                RegWrite  = !w_is_cmp;
                ResultSrc = 2'b00;
                if (S || w_is_cmp) begin
                    flags_d = alu_flags;
                end
                retired_d = retired_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = L1 ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
                retired_d = retired_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retired_d = retired_q + 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_BRANCH: begin
                PCWrite   = 1'b1;
                LinkWrite = L2;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                retired_d = retired_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // A stalled access keeps its state, so only stalls carry the count forward.
        if (w_stall) begin
            if (w_wait_inc == WAIT_W'(WAIT_MAX)) begin
                state_d = S_FAULT;
            end else begin
                wait_d = w_wait_inc;
            end
        end

        // The cycle that is being reset must not leave half an instruction behind.
        if (!rst_n) begin
            mem_req   = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            LinkWrite = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit_multiciclo
// Description : Randomized self-checking bench for control_unit_multiciclo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_multiciclo;

    localparam int c_WAIT_MAX = 15;
    localparam int c_CNT_W    = 4;
    // Bits that survive the reset cycle: selects and fault, not the strobes.
    localparam logic [15:0] c_RST_KEEP = 16'h03FD;
    localparam logic [3:0]  c_OPS   [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    localparam int          c_CODES [5] = '{0, 1, 2, 3, 1};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         Cond;
    logic [1:0]         Op;
    logic               I;
    logic [3:0]         OpCode;
    logic               S;
    logic               L1;
    logic               L2;
    logic [3:0]         alu_flags;
    logic               mem_ready;
    logic               mem_req, IRWrite, PCWrite, MemWrite, RegWrite, LinkWrite, AdrSrc, ALUSrcA;
    logic [1:0]         ALUSrcB, ResultSrc, ALUControl;
    logic [3:0]         flags;
    logic [c_CNT_W-1:0] retired;
    logic               illegal, fault;
    logic [15:0]        w_obs;

    always #5 clk = ~clk;

    control_unit_multiciclo #(.WAIT_MAX(c_WAIT_MAX), .CNT_W(c_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .I(I), .OpCode(OpCode),
        .S(S), .L1(L1), .L2(L2), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .LinkWrite(LinkWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .flags(flags), .retired(retired), .illegal(illegal), .fault(fault)
    );

    assign w_obs = {mem_req, IRWrite, PCWrite, MemWrite, RegWrite, LinkWrite, AdrSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ALUControl, illegal, fault};

    typedef struct {
        logic [15:0] vec;
        logic        ready;
        logic [3:0]  aluf;
        logic        rstn;
        logic [3:0]  eflags;
        int          eret;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic        i;
        logic [3:0]  opc;
        logic        s;
        logic        l1;
        logic        l2;
    } cyc_t;

    cyc_t       q[$];
    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    logic [3:0] mflags;
    int         mret;
    logic [3:0] cur_cond, cur_opc;
    logic [1:0] cur_op;
    logic       cur_i, cur_s, cur_l1, cur_l2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic mreq, ir, pc, mw, rw, lw, adr, srca,
                                        input logic [1:0] srcb, res, aluc,
                                        input logic ill, flt);
        return {mreq, ir, pc, mw, rw, lw, adr, srca, srcb, res, aluc, ill, flt};
    endfunction

    // Condition table: pairs of base test and its inverse, keyed by Cond[3:1].
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
        logic n, z, cc, v, base;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cc;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cc && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? !base : base;
`else
        return 1'b1 | (^{c, f});
`endif
    endfunction

    function automatic int alu_code(input logic [3:0] opc);
        for (int k = 0; k < 5; k++) begin
            if (c_OPS[k] == opc) return c_CODES[k];
        end
        return -1;
    endfunction

    function automatic int rnd_wait();
        int r;
        r = int'($urandom % 100);
        if (r < 60) return 0;
        if (r < 90) return 1 + int'($urandom % 3);
        if (r < 96) return c_WAIT_MAX - 1;
        return c_WAIT_MAX;
    endfunction

    task automatic push_full(input logic [15:0] vec, input logic rdy, input logic [3:0] aluf,
                             input logic rstn);
        cyc_t c;
        c.vec = vec;       c.ready = rdy;    c.aluf = aluf;  c.rstn = rstn;
        c.eflags = mflags; c.eret = mret;
        c.cond = cur_cond; c.op = cur_op;    c.i = cur_i;    c.opc = cur_opc;
        c.s = cur_s;       c.l1 = cur_l1;    c.l2 = cur_l2;
        q.push_back(c);
    endtask

    task automatic push(input logic [15:0] vec, input logic rdy, input logic [3:0] aluf);
        push_full(vec, rdy, aluf, 1'b1);
    endtask

    // One reset edge, then the IDLE cycle that follows it.
    task automatic reset_seq(input logic [15:0] vec_now);
        push_full(vec_now & c_RST_KEEP, 1'($urandom), 4'($urandom), 1'b0);
        mflags = 4'h0;
        mret   = 0;
        push(16'h0, 1'($urandom), 4'($urandom));
    endtask

    task automatic mem_phase(input logic [15:0] stall_vec, input int w, output logic faulted);
        logic [15:0] v_fault;
        v_fault = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        faulted = 1'b0;
        if (w >= c_WAIT_MAX) begin
            repeat (c_WAIT_MAX) push(stall_vec, 1'b0, 4'($urandom));
            repeat (3) push(v_fault, 1'($urandom), 4'($urandom));
            reset_seq(v_fault);
            faulted = 1'b1;
        end else begin
            repeat (w) push(stall_vec, 1'b0, 4'($urandom));
        end
    endtask

    task automatic build(input logic [3:0] cond, input logic [1:0] op, input logic i,
                         input logic [3:0] opc, input logic s, input logic l1, input logic l2,
                         input int wf, input int wm);
        logic       flt, cmp;
        logic [3:0] af;
        int         code;
        logic [1:0] srcb;
        cur_cond = cond; cur_op = op; cur_i = i; cur_opc = opc;
        cur_s = s; cur_l1 = l1; cur_l2 = l2;

        mem_phase(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0, 0), wf, flt);
        if (flt) return;
        push(mk(1, 1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0, 0), 1'b1, 4'($urandom));

        if (!cond_ok(cond, mflags)) begin
            push(16'h0, 1'($urandom), 4'($urandom));
            return;
        end
        if (op == 2'b11) begin
            push(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0), 1'($urandom), 4'($urandom));
            return;
        end
        push(16'h0, 1'($urandom), 4'($urandom));

        if (op == 2'b00) begin
            code = alu_code(opc);
            srcb = i ? 2'b01 : 2'b00;
            if (code < 0) begin
                push(mk(0, 0, 0, 0, 0, 0, 0, 0, srcb, 2'b00, 2'b00, 1, 0), 1'($urandom), 4'($urandom));
                return;
            end
            push(mk(0, 0, 0, 0, 0, 0, 0, 0, srcb, 2'b00, 2'(code), 0, 0), 1'($urandom), 4'($urandom));
            cmp = (opc == 4'b1010);
            af  = 4'($urandom);
            push(mk(0, 0, 0, 0, !cmp, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), 1'($urandom), af);
            if (s || cmp) mflags = af;
            mret = (mret + 1) % (1 << c_CNT_W);
        end else if (op == 2'b01) begin
            push(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0), 1'($urandom), 4'($urandom));
            if (l1) begin
                mem_phase(mk(1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), wm, flt);
                if (flt) return;
                push(mk(1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), 1'b1, 4'($urandom));
                push(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0), 1'($urandom), 4'($urandom));
            end else begin
                mem_phase(mk(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), wm, flt);
                if (flt) return;
                push(mk(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), 1'b1, 4'($urandom));
            end
            mret = (mret + 1) % (1 << c_CNT_W);
        end else begin
            push(mk(0, 0, 1, 0, 0, l2, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0), 1'($urandom), 4'($urandom));
            mret = (mret + 1) % (1 << c_CNT_W);
        end
    endtask

    task automatic run_q();
        foreach (q[j]) begin
            @(negedge clk);
            rst_n     = q[j].rstn;
            mem_ready = q[j].ready;
            alu_flags = q[j].aluf;
            Cond      = q[j].cond;
            Op        = q[j].op;
            I         = q[j].i;
            OpCode    = q[j].opc;
            S         = q[j].s;
            L1        = q[j].l1;
            L2        = q[j].l2;
            #1;
            check("outputs", 32'(w_obs), 32'(q[j].vec));
            check("flags", 32'(flags), 32'(q[j].eflags));
            check("retired", 32'(retired), 32'(q[j].eret));
            cyc++;
        end
        q.delete();
    endtask

    task automatic do_instr(input logic [3:0] cond, input logic [1:0] op, input logic i,
                            input logic [3:0] opc, input logic s, input logic l1, input logic l2,
                            input int wf, input int wm, input logic may_abort);
        cyc_t c;
        int   k;
        build(cond, op, i, opc, s, l1, l2, wf, wm);
        if (may_abort && ($urandom % 12 == 0) && q.size() > 1) begin
            k = 1 + int'($urandom % (q.size() - 1));
            c = q[k];
            while (q.size() > k) void'(q.pop_back());
            mflags = c.eflags;
            mret   = c.eret;
            reset_seq(c.vec);
        end
        run_q();
    endtask

    initial begin
        logic [3:0] cond, opc;
        logic [1:0] op;
        int         r;
        rst_n = 1'b0; mem_ready = 1'b0; alu_flags = 4'h0; Cond = 4'hE; Op = 2'b00;
        I = 1'b0; OpCode = 4'h4; S = 1'b0; L1 = 1'b0; L2 = 1'b0;
        cur_cond = 4'hE; cur_op = 2'b00; cur_i = 1'b0; cur_opc = 4'h4;
        cur_s = 1'b0; cur_l1 = 1'b0; cur_l2 = 1'b0;
        mflags = 4'h0;
        mret   = 0;

        reset_seq(16'h0);
        run_q();

        do_instr(4'b1110, 2'b00, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);  // ADD S
        do_instr(4'b1110, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0);  // LDR, 3 waits
        do_instr(4'b0000, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // BEQ
        do_instr(4'b1110, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);  // BL
        do_instr(4'b1110, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 2, 1'b0);  // STR
        do_instr(4'b1110, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // Op=11
        do_instr(4'b1110, 2'b00, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);  // bad opcode
        do_instr(4'b1110, 2'b00, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // CMP
        do_instr(4'b1110, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 14, 14, 1'b0); // max waits
        do_instr(4'b1110, 2'b00, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 15, 0, 1'b0); // fetch timeout

        for (int n = 0; n < 300; n++) begin
            cond = ($urandom % 2 == 0) ? 4'b1110 : 4'($urandom);
            r    = int'($urandom % 10);
            op   = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            opc  = ($urandom % 4 != 0) ? c_OPS[$urandom % 5] : 4'($urandom);
            do_instr(cond, op, 1'($urandom), opc, 1'($urandom), 1'($urandom), 1'($urandom),
                     rnd_wait(), rnd_wait(), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
